// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one 128-bit backing memory between the L1 instruction cache (I port)
// and the L1 data cache (D port). One memory transaction is in flight at a
// time. The winner's request is latched in IDLE, presented to memory in
// GRANT/WAIT, and the memory's completion is routed back to the winner only
// as a single-cycle ready pulse during RELEASE.
//
// State sequence: IDLE -> GRANT -> WAIT -> RELEASE -> IDLE
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   i_valid/i_address I-cache line fill request (held until i_ready)
//   i_ready/i_rdata   I completion pulse and returned line
//   d_valid/d_write   D-cache request; d_write=1 write-back, 0 line fill
//   d_address/d_wdata D-cache line address and write-back line
//   d_ready/d_rdata   D completion pulse and returned line
//   mem_valid/...     request to memory, held stable until mem_ready
//   mem_rdata         memory read line
//   mem_ready         memory completion pulse (honoured only in WAIT)
//   busy              high in every state except IDLE
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN  defined: on contention the winner is the priority
//                       pointer, which moves to the other requester after
//                       every completed grant.
//                       undefined: fixed priority, D always beats I.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_ready,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_valid,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,

    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state;

    // 1 = the transaction in flight belongs to the D port.
    logic   winner_d;
    // Winner chosen from the current request inputs (only used in IDLE).
    logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D has priority on the next contended cycle.
    logic   ptr_d;

    always_comb begin
        pick_d = d_valid;
        if (d_valid && i_valid) begin
            pick_d = ptr_d;
        end
    end
`else
    always_comb begin
        pick_d = d_valid;
    end
`endif

    // The mem_* outputs double as the latched copy of the winning request:
    // they are loaded once on leaving IDLE and left untouched afterwards, so
    // requester inputs moving during GRANT/WAIT cannot disturb the memory side.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            winner_d    <= 1'b0;
            mem_valid   <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            i_ready     <= 1'b0;
            d_ready     <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            busy        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d       <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid || d_valid) begin
                        winner_d    <= pick_d;
                        mem_address <= pick_d ? d_address : i_address;
                        // I grants are always fills.
                        mem_write   <= pick_d & d_write;
                        mem_wdata   <= pick_d ? d_wdata : '0;
                        mem_valid   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_GRANT;
                    end
                end

                // mem_valid is already up; memory gets one full cycle to see
                // the request before completion is honoured.
                S_GRANT: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (winner_d) begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ready <= 1'b1;
                        end
                        state <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   <= ~winner_d;
`endif
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Cycle-stepped bench for mem_port_arbiter. Requests are queued per port and
// the expected service order (with expected address/write/wdata and the line
// the memory model returns) is pushed to a scoreboard queue. A behavioural
// memory responder checks the memory-side request against the scoreboard head
// and answers after a programmable delay; the ready monitor pops the
// scoreboard and checks the returned port and line.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [AW-1:0] i_address;
    logic          i_ready;
    logic [LW-1:0] i_rdata;
    logic          d_valid;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic          d_ready;
    logic [LW-1:0] d_rdata;
    logic          mem_valid;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .i_address   (i_address),
        .i_ready     (i_ready),
        .i_rdata     (i_rdata),
        .d_valid     (d_valid),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .mem_valid   (mem_valid),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy)
    );

    typedef struct {
        bit            is_d;
        logic [AW-1:0] addr;
        bit            write;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } txn_t;

    txn_t order_q[$];
    txn_t i_req_q[$];
    txn_t d_req_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   txn_no = 0;

    int   mem_delay   = 2;
    bit   resp_active = 1'b0;
    int   resp_cnt    = 0;
    txn_t resp_item;

    int   req_cycle_i = 0;
    int   ready_cycle = 0;

    localparam logic [LW-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] LINE_DB = {4{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] LINE_C3 = {16{8'hC3}};

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input bit is_d, input logic [AW-1:0] a, input bit w,
                                input logic [LW-1:0] wd, input logic [LW-1:0] rd);
        txn_t t;
        t.is_d  = is_d;
        t.addr  = a;
        t.write = w;
        t.wdata = wd;
        t.rdata = rd;
        return t;
    endfunction

    task automatic push_i(input logic [AW-1:0] a, input logic [LW-1:0] rd);
        i_req_q.push_back(mk(1'b0, a, 1'b0, '0, rd));
    endtask

    task automatic push_d(input logic [AW-1:0] a, input bit w, input logic [LW-1:0] wd,
                          input logic [LW-1:0] rd);
        d_req_q.push_back(mk(1'b1, a, w, wd, rd));
    endtask

    task automatic expect_i(input logic [AW-1:0] a, input logic [LW-1:0] rd);
        order_q.push_back(mk(1'b0, a, 1'b0, '0, rd));
    endtask

    task automatic expect_d(input logic [AW-1:0] a, input bit w, input logic [LW-1:0] wd,
                            input logic [LW-1:0] rd);
        order_q.push_back(mk(1'b1, a, w, wd, rd));
    endtask

    task automatic check_mem_side(input txn_t e);
        check("mem_address", LW'(mem_address), LW'(e.addr));
        check("mem_write",   LW'(mem_write),   LW'(e.write));
        if (e.write) begin
            check("mem_wdata", mem_wdata, e.wdata);
        end
    endtask

    // One clock cycle: sample after the edge, check, then drive the next inputs.
    task automatic step();
        txn_t e;
        bit   i_rdy;
        bit   d_rdy;
        @(posedge clk);
        #1;
        cycle++;
        i_rdy = i_ready;
        d_rdy = d_ready;

        // Ready monitor
        if (i_rdy || d_rdy) begin
            ready_cycle = cycle;
            check("ready_exclusive", LW'(i_rdy & d_rdy), LW'(0));
            if (order_q.size() == 0) begin
                check("spurious_ready", LW'(1), LW'(0));
            end else begin
                e = order_q.pop_front();
                check("ready_port", LW'(d_rdy), LW'(e.is_d));
                if (e.is_d) check("d_rdata", d_rdata, e.rdata);
                else        check("i_rdata", i_rdata, e.rdata);
                txn_no++;
                $display("txn %0d: port=%s addr=%h write=%0d line=%h cycle=%0d",
                         txn_no, e.is_d ? "D" : "I", e.addr, e.write, e.rdata, cycle);
            end
        end

        // Memory responder
        if (mem_ready) begin
            mem_ready   = 1'b0;
            resp_active = 1'b0;
            check("mem_valid_dropped", LW'(mem_valid), LW'(0));
        end else if (resp_active) begin
            check("mem_valid_held", LW'(mem_valid), LW'(1));
            check("busy_active", LW'(busy), LW'(1));
            check_mem_side(resp_item);
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = resp_item.rdata;
            end
        end else if (mem_valid) begin
            if (order_q.size() == 0) begin
                check("unexpected_mem_valid", LW'(1), LW'(0));
            end else begin
                resp_item   = order_q[0];
                check_mem_side(resp_item);
                resp_active = 1'b1;
                resp_cnt    = mem_delay;
            end
        end

        // Requesters: retire on ready, present the next queued request at once
        if (i_rdy && i_req_q.size() > 0) begin
            e = i_req_q.pop_front();
            i_valid = 1'b0;
        end
        if (!i_valid && i_req_q.size() > 0) begin
            i_valid     = 1'b1;
            i_address   = i_req_q[0].addr;
            req_cycle_i = cycle;
        end
        if (d_rdy && d_req_q.size() > 0) begin
            e = d_req_q.pop_front();
            d_valid = 1'b0;
        end
        if (!d_valid && d_req_q.size() > 0) begin
            d_valid   = 1'b1;
            d_write   = d_req_q[0].write;
            d_address = d_req_q[0].addr;
            d_wdata   = d_req_q[0].wdata;
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        step();
        while ((order_q.size() != 0 || busy || i_valid || d_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("timeout", LW'(1), LW'(0));
    endtask

    task automatic wait_mem_active(input int budget);
        int n = 0;
        while (!resp_active && n < budget) begin
            step();
            n++;
        end
        if (!resp_active) check("mem_request_timeout", LW'(1), LW'(0));
    endtask

    initial begin
        reset     = 1'b0;
        i_valid   = 1'b0;
        i_address = '0;
        d_valid   = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid",   LW'(mem_valid),   LW'(0));
        check("rst_mem_write",   LW'(mem_write),   LW'(0));
        check("rst_mem_address", LW'(mem_address), LW'(0));
        check("rst_busy",        LW'(busy),        LW'(0));
        check("rst_ready",       LW'({i_ready, d_ready}), LW'(0));
        check("rst_rdata",       i_rdata | d_rdata, LW'(0));
        reset = 1'b1;
        step();

        // I fill alone, memory answers 2 cycles after mem_valid
        mem_delay = 2;
        push_i(32'h40, LINE_A5);
        expect_i(32'h40, LINE_A5);
        run(40);
        check("i_latency_d2", LW'(ready_cycle - req_cycle_i), LW'(4));

        // D write-back
        mem_delay = 3;
        push_d(32'h80, 1'b1, 128'h1234, LINE_DB);
        expect_d(32'h80, 1'b1, 128'h1234, LINE_DB);
        run(40);
        check("i_rdata_hold", i_rdata, LINE_A5);

        // Minimum latency I fill
        mem_delay = 1;
        push_i(32'hC0, LINE_C3);
        expect_i(32'hC0, LINE_C3);
        run(40);
        check("i_latency_min", LW'(ready_cycle - req_cycle_i), LW'(3));
        check("d_rdata_hold", d_rdata, LINE_DB);

        // Contention, one request each: D first in both builds
        mem_delay = 2;
        push_i(32'h100, 128'h1001);
        push_d(32'h180, 1'b0, '0, 128'h1801);
        expect_d(32'h180, 1'b0, '0, 128'h1801);
        expect_i(32'h100, 128'h1001);
        run(60);

        // Contention, two back-to-back requests each
        push_d(32'h200, 1'b0, '0, 128'h2001);
        push_d(32'h240, 1'b1, 128'h55AA, 128'h2401);
        push_i(32'h300, 128'h3001);
        push_i(32'h340, 128'h3401);
`ifdef ARB_ROUND_ROBIN_EN
        expect_d(32'h200, 1'b0, '0, 128'h2001);
        expect_i(32'h300, 128'h3001);
        expect_d(32'h240, 1'b1, 128'h55AA, 128'h2401);
        expect_i(32'h340, 128'h3401);
`else
        expect_d(32'h200, 1'b0, '0, 128'h2001);
        expect_d(32'h240, 1'b1, 128'h55AA, 128'h2401);
        expect_i(32'h300, 128'h3001);
        expect_i(32'h340, 128'h3401);
`endif
        run(100);

        // Stray mem_ready in IDLE is ignored
        mem_rdata = {4{32'hBAD0_BAD0}};
        mem_ready = 1'b1;
        repeat (3) step();
        check("stray_busy",     LW'(busy),        LW'(0));
        check("stray_address",  LW'(mem_address), LW'(32'h340));
        check("stray_i_rdata",  i_rdata, 128'h3401);
        check("stray_d_rdata",  d_rdata, 128'h2401);

        // Request inputs change during WAIT: latched copy kept
        mem_delay = 4;
        push_i(32'h400, 128'h4001);
        expect_i(32'h400, 128'h4001);
        wait_mem_active(10);
        step();
        i_address = 32'h999;
        d_address = 32'h777;
        d_write   = 1'b1;
        run(40);
        d_write   = 1'b0;

        // Reset asserted mid-WAIT
        mem_delay = 6;
        push_i(32'h500, 128'h5001);
        expect_i(32'h500, 128'h5001);
        wait_mem_active(10);
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        check("rst_wait_mem_valid", LW'(mem_valid), LW'(0));
        check("rst_wait_busy",      LW'(busy),      LW'(0));
        check("rst_wait_ready",     LW'({i_ready, d_ready}), LW'(0));
        order_q.delete();
        i_req_q.delete();
        d_req_q.delete();
        i_valid     = 1'b0;
        d_valid     = 1'b0;
        resp_active = 1'b0;
        mem_ready   = 1'b0;
        repeat (3) step();
        check("rst_wait_i_rdata", i_rdata, LW'(0));
        reset = 1'b1;
        repeat (3) step();
        check("post_rst_idle", LW'({busy, mem_valid}), LW'(0));

        // Recovery after reset
        mem_delay = 2;
        push_i(32'h600, 128'h6001);
        expect_i(32'h600, 128'h6001);
        run(40);
        check("final_busy", LW'(busy), LW'(0));
        check("final_scoreboard_empty", LW'(order_q.size()), LW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
